// File: rtl/uart_div_sched_if.sv
// rtl/uart_div_sched_if.sv - byte stream and divider handshake bundle for uart_div_sched
interface uart_div_sched_if #(
    parameter int DATA_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              div_start;
    logic [DATA_W-1:0] div_a;
    logic [DATA_W-1:0] div_b;
    logic              div_done;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_r;

    modport master (
        input  rx_valid, rx_data, tx_busy, div_done, div_q, div_r,
        output tx_start, tx_data, div_start, div_a, div_b
    );

    modport slave (
        output rx_valid, rx_data, tx_busy, div_done, div_q, div_r,
        input  tx_start, tx_data, div_start, div_a, div_b
    );
endinterface

// File: rtl/uart_div_sched.sv
// rtl/uart_div_sched.sv - UART request/response sequencer around a shared multi-cycle divider
module uart_div_sched #(
    parameter int         DATA_W      = 16,
    parameter int         TIMEOUT_CYC = 500000,
    parameter logic [7:0] ST_OK       = 8'h00,
    parameter logic [7:0] ST_DIV0     = 8'hE1
) (
    input  logic              clk,
    input  logic              rst,
    uart_div_sched_if.master  bus,
    output logic [DATA_W-1:0] led_q,
    output logic              busy,
    output logic              timeout,
    output logic              ovr
);
    localparam int FRAME_B = 2 * DATA_W / 8;
    localparam int RSP_B   = FRAME_B + 1;
    localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int FI_W    = $clog2(FRAME_B);
    localparam int RI_W    = $clog2(RSP_B);
    localparam logic [FI_W-1:0]  FI_LAST  = FI_W'(FRAME_B - 1);
    localparam logic [RI_W-1:0]  RI_LAST  = RI_W'(RSP_B - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_COLLECT, S_CHECK, S_LAUNCH, S_WAIT_DIV,
        S_LOAD_RSP, S_SEND, S_TX_GUARD, S_TX_WAIT
    } state_t;

    state_t              state, state_nxt;
    logic [FI_W-1:0]     fidx;
    logic [RI_W-1:0]     ridx;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] frame;
    // Response bytes packed low-first: status, q, r.
    logic [8*RSP_B-1:0]  rsp;
    logic [7:0]          tx_hold;
    logic [7:0]          rsp_byte;
    logic                rx_take;
    logic                b_zero;

    assign rx_take     = bus.rx_valid && (state == S_COLLECT);
    assign b_zero      = (frame[2*DATA_W-1:DATA_W] == '0);
    assign rsp_byte    = rsp[8*ridx +: 8];
    assign busy        = (state != S_COLLECT);
    assign ovr         = bus.rx_valid && (state != S_COLLECT);
    assign bus.div_a   = frame[DATA_W-1:0];
    assign bus.div_b   = frame[2*DATA_W-1:DATA_W];
    // New byte appears exactly on the launch pulse and is held until the next one.
    assign bus.tx_data = bus.tx_start ? rsp_byte : tx_hold;

    always_comb begin
        state_nxt     = state;
        bus.div_start = 1'b0;
        bus.tx_start  = 1'b0;
        timeout       = 1'b0;
        case (state)
            S_COLLECT: begin
                if (rx_take && fidx == FI_LAST) state_nxt = S_CHECK;
                timeout = !bus.rx_valid && (fidx != '0) && (cnt == CNT_LAST);
            end
            S_CHECK:    state_nxt = b_zero ? S_LOAD_RSP : S_LAUNCH;
            S_LAUNCH: begin
                bus.div_start = 1'b1;
                state_nxt     = S_WAIT_DIV;
            end
            S_WAIT_DIV: if (bus.div_done) state_nxt = S_LOAD_RSP;
            S_LOAD_RSP: state_nxt = S_SEND;
            S_SEND: begin
                if (!bus.tx_busy) begin
                    bus.tx_start = 1'b1;
                    state_nxt    = S_TX_GUARD;
                end
            end
            S_TX_GUARD: state_nxt = S_TX_WAIT;
            S_TX_WAIT:  if (!bus.tx_busy) state_nxt = (ridx == RI_LAST) ? S_COLLECT : S_SEND;
            default:    state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_COLLECT;
            fidx    <= '0;
            ridx    <= '0;
            cnt     <= '0;
            frame   <= '0;
            rsp     <= '0;
            tx_hold <= '0;
            led_q   <= '0;
        end else begin
            state <= state_nxt;
            if (rx_take) begin
                frame[8*fidx +: 8] <= bus.rx_data;
                fidx               <= (fidx == FI_LAST) ? '0 : fidx + 1'b1;
                cnt                <= '0;
            end else if (timeout) begin
                fidx <= '0;
                cnt  <= '0;
            end else if (state == S_COLLECT && fidx != '0) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_CHECK && b_zero)
                rsp <= {frame[DATA_W-1:0], {DATA_W{1'b1}}, ST_DIV0};
            if (state == S_WAIT_DIV && bus.div_done) begin
                rsp   <= {bus.div_r, bus.div_q, ST_OK};
                led_q <= bus.div_q;
            end
            if (state == S_LOAD_RSP) ridx <= '0;
            if (bus.tx_start) tx_hold <= rsp_byte;
            if (state == S_TX_WAIT && !bus.tx_busy && ridx != RI_LAST) ridx <= ridx + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_div_sched.sv
// tb/tb_uart_div_sched.sv - directed plus randomized bench for uart_div_sched
module tb_uart_div_sched;
    localparam int TO      = 64;
    localparam int DIV_LAT = 17;

    logic        clk;
    logic        rst;
    logic [15:0] led_q;
    logic        busy, timeout, ovr;

    uart_div_sched_if #(.DATA_W(16)) bus ();

    uart_div_sched #(
        .DATA_W(16), .TIMEOUT_CYC(TO), .ST_OK(8'h00), .ST_DIV0(8'hE1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .led_q(led_q), .busy(busy), .timeout(timeout), .ovr(ovr)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          rx_cyc = 0;
    int          tx_len = 3;
    int          stray_req = 0;
    logic [15:0] led_exp = 16'h0;

    // divider model state
    int          cd = 0, div_starts = 0, div_cyc = 0, done_cyc = 0, stray_served = 0;
    logic [15:0] pa = 16'h0, pb = 16'h0;
    // transmitter model state
    logic [7:0]  txq[$];
    int          txcq[$];
    logic [7:0]  last_tx = 8'h0;
    bit          tx_track = 0, tx_pend = 0;
    int          tx_left = 0, tx_viol = 0, tx_unstable = 0;
    // pulse monitors
    int          ovr_cnt = 0, to_cnt = 0, to_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bus.div_done = 1'b0;
        if (!rst) begin
            cd = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                bus.div_done = 1'b1;
                bus.div_q    = (pb == 0) ? 16'hFFFF : pa / pb;
                bus.div_r    = (pb == 0) ? pa : pa % pb;
                done_cyc     = cyc;
            end
        end else if (stray_req > stray_served) begin
            stray_served++;
            bus.div_done = 1'b1;
            bus.div_q    = 16'h5555;
            bus.div_r    = 16'h5555;
        end
        #1;
        if (rst && bus.div_start) begin
            div_starts++;
            pa      = bus.div_a;
            pb      = bus.div_b;
            div_cyc = cyc;
            cd      = DIV_LAT;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bus.tx_busy = 1'b0;
            tx_left     = 0;
            tx_pend     = 0;
        end else if (tx_pend) begin
            tx_pend     = 0;
            bus.tx_busy = 1'b1;
            tx_left     = tx_len;
        end else if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) bus.tx_busy = 1'b0;
        end
        #1;
        if (!rst) begin
            tx_track = 0;
        end else if (bus.tx_start) begin
            if (bus.tx_busy) tx_viol++;
            txq.push_back(bus.tx_data);
            txcq.push_back(cyc);
            last_tx  = bus.tx_data;
            tx_track = 1;
            tx_pend  = 1;
        end else if (tx_track && bus.tx_data !== last_tx) begin
            tx_unstable++;
        end
    end

    always @(negedge clk) begin
        #2;
        if (ovr) ovr_cnt++;
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; leaves rx_valid high for exactly one cycle.
    task automatic send_byte(input logic [7:0] d, input bit exp_ovr);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        rx_cyc       = cyc;
        #1;
        chk("ovr_on_rx", ovr, exp_ovr);
        if (!exp_ovr) chk("no_timeout_on_rx", timeout, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input int gap);
        send_byte(a[7:0], 1'b0);  idle(gap);
        send_byte(a[15:8], 1'b0); idle(gap);
        send_byte(b[7:0], 1'b0);  idle(gap);
        send_byte(b[15:8], 1'b0);
    endtask

    task automatic do_frame(input logic [15:0] a, input logic [15:0] b, input int gap, input bit inj);
        logic [7:0]  exp [5];
        logic [15:0] q, r;
        int          n_tx, n_div, n_to, n_ovr, b3;
        bit          inj_tx;
        if (b == 16'h0) begin
            exp[0] = 8'hE1; q = 16'hFFFF; r = a;
        end else begin
            exp[0] = 8'h00; q = a / b; r = a % b;
        end
        exp[1] = q[7:0]; exp[2] = q[15:8]; exp[3] = r[7:0]; exp[4] = r[15:8];
        n_tx = txq.size(); n_div = div_starts; n_to = to_cnt; n_ovr = ovr_cnt;
        send_frame(a, b, gap);
        b3     = rx_cyc;
        inj_tx = inj;
        for (int i = 0; i < 20000; i++) begin
            if (txq.size() >= n_tx + 5 && !busy) break;
            if (inj && i == 4) send_byte(8'hAA, 1'b1);
            else if (inj_tx && txq.size() == n_tx + 2) begin
                inj_tx = 0;
                send_byte(8'hAA, 1'b1);
            end else @(negedge clk);
        end
        chk("tx_count", txq.size() - n_tx, 5);
        chk("idle_after_rsp", busy, 1'b0);
        chk("div_start_count", div_starts - n_div, (b != 16'h0) ? 1 : 0);
        if (txq.size() >= n_tx + 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("rsp_byte%0d", k), txq[n_tx+k], exp[k]);
            if (b != 16'h0) begin
                chk("div_a", pa, a);
                chk("div_b", pb, b);
                chk("div_start_lat", div_cyc, b3 + 2);
                chk("tx_after_done_lat", txcq[n_tx], done_cyc + 2);
            end else begin
                chk("tx_div0_lat", txcq[n_tx], b3 + 3);
            end
        end
        if (b != 16'h0) led_exp = q;
        chk("led_q", led_q, led_exp);
        chk("timeout_count", to_cnt - n_to, 0);
        chk("ovr_count", ovr_cnt - n_ovr, inj ? 2 : 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tx_start"}, bus.tx_start, 1'b0);
        chk({tag, "_tx_data"}, bus.tx_data, 8'h00);
        chk({tag, "_div_start"}, bus.div_start, 1'b0);
        chk({tag, "_div_ab"}, {bus.div_a, bus.div_b}, 32'h0);
        chk({tag, "_led_q"}, led_q, 16'h0);
        chk({tag, "_flags"}, {busy, timeout, ovr}, 3'b000);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          n_tx, n_div, n_to, c0;
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        chk_zero("reset");
        rst = 1'b1;
        idle(2);

        do_frame(16'd100, 16'd7, 0, 0);
        do_frame(16'h1234, 16'h0000, 1, 0);

        n_to = to_cnt;
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        c0 = rx_cyc;
        idle(TO);
        chk("timeout_pulses", to_cnt - n_to, 1);
        chk("timeout_cycle", to_cyc, c0 + TO);
        do_frame(16'd9, 16'd3, 0, 0);

        do_frame(16'h0203, 16'h0011, TO - 1, 0);
        do_frame(16'd5000, 16'd9, 2, 1);
        do_frame(16'h4321, 16'h0000, 0, 1);

        n_tx = txq.size();
        stray_req++;
        idle(4);
        chk("stray_done_led", led_q, led_exp);
        chk("stray_done_tx", txq.size() - n_tx, 0);
        chk("stray_done_busy", busy, 1'b0);

        tx_len = 1000;
        do_frame(16'hFFFF, 16'h00FF, 0, 0);
        tx_len = 3;

        n_div = div_starts;
        send_frame(16'd1000, 16'd33, 0);
        for (int i = 0; i < 100 && div_starts == n_div; i++) @(negedge clk);
        chk("rst1_launched", div_starts - n_div, 1);
        idle(4);
        rst = 1'b0;
        #1;
        chk_zero("rst_wait_div");
        idle(2);
        rst = 1'b1;
        n_tx = txq.size(); n_div = div_starts;
        idle(60);
        chk("rst1_no_tx", txq.size() - n_tx, 0);
        chk("rst1_no_div", div_starts - n_div, 0);
        led_exp = 16'h0;

        tx_len = 20;
        n_tx = txq.size();
        send_frame(16'd500, 16'd7, 0);
        for (int i = 0; i < 500 && txq.size() < n_tx + 3; i++) @(negedge clk);
        chk("rst2_three_sent", txq.size() - n_tx, 3);
        idle(4);
        rst = 1'b0;
        #1;
        chk_zero("rst_tx_wait");
        idle(2);
        rst = 1'b1;
        n_tx = txq.size(); n_div = div_starts;
        idle(60);
        chk("rst2_no_tx", txq.size() - n_tx, 0);
        chk("rst2_no_div", div_starts - n_div, 0);
        tx_len = 3;
        do_frame(16'd777, 16'd10, 0, 0);

        for (int n = 0; n < 12; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            tx_len = $urandom_range(1, 8);
            do_frame(ra, rb, $urandom_range(0, TO - 1), 1'($urandom_range(0, 1)));
        end

        chk("tx_start_while_busy", tx_viol, 0);
        chk("tx_data_stability", tx_unstable, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
